decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the single-cycle MIPS instruction decoder. Sits between fetch and the ID/EX register.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes the head entry into a registered output slot with a valid/ready handshake.
- Resolves destination register, extended immediate and write-enable, counts undefined instructions, and supports pipeline flush on branch/jump redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- PC_W, 32, width of the program counter carried with each instruction.
- CNT_W, 16, width of the saturating undefined-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all queued and output-slot instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept; equals !full.
- in_inst  input  32  instruction word.
- in_pc  input  PC_W  PC of in_inst.
- out_valid  output  1  output slot holds a decoded instruction.
- out_ready  input  1  downstream consumes the slot.
- out_op  output  4  0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 jal, 7 und, 8 lui, 9 j, 10 jr, 11 slt.
- out_rs  output  5  source register 1.
- out_rt  output  5  source register 2.
- out_dst  output  5  destination register.
- out_imm  output  32  extended immediate.
- out_target  output  26  jump target field.
- out_pc  output  PC_W  PC of the decoded instruction.
- out_wr_en  output  1  instruction writes the register file.
- und_count  output  CNT_W  number of undefined instructions decoded.

Behaviour:
- Reset: FIFO empty, in_ready=1, out_valid=0, und_count=0. All out_* fields are 0, with out_op=7.
- Push: when in_valid && in_ready && !flush, write {inst, pc} at the write pointer; the pointer wraps modulo DEPTH.
- Full/empty tracking: an occupancy counter of width log2(DEPTH)+1. in_ready is computed from registered occupancy only, with no same-cycle pass-through.
- Output slot update: the slot loads when (!out_valid || out_ready) && FIFO non-empty. The head is decoded combinationally and registered, and the read pointer advances.
- If out_ready is high and the FIFO is empty, out_valid falls to 0.
- Latency: an instruction accepted at edge N is visible on out_* after edge N+1 at the earliest.
- Throughput: one instruction per cycle when out_ready is held high.
- Simultaneous push and pop: occupancy is unchanged. A push when full is impossible because in_ready=0.
- Flush: on the next edge, empty the FIFO, set out_valid=0 and reset the pointers. An in_valid arriving in the flush cycle is dropped. und_count is not cleared. rst has priority over flush.
- Opcode decode, 6-bit opcode [31:26]:
  - 000000 with funct [5:0] 100001 is addu; 100010 is subu.
  - 001101 is ori, 100011 is lw, 101011 is sw, 000100 is beq, 000011 is jal.
  - Everything else is und.
- Field gating:
  - R-type: rs, rt, dst=rd; imm and target are 0.
  - I-type: rs, rt, imm. sw and beq: dst=0. ori and lw: dst=rt.
  - jal: target=inst[25:0], dst=31, rs=rt=0.
  - und: all fields 0.
- Immediate extension: ori is zero-extended; lw, sw and beq are sign-extended from bit 15.
- Write enable: out_wr_en = op in {addu, subu, ori, lw, jal, lui, slt} && out_dst != 0.
- und_count increments by 1 when an und instruction loads into the output slot. It saturates at all-ones.

Optional Feature:
- Macro: DECODE_EXT_OPS_EN.
- Defined: decodes four extra instructions.
  - lui (001111): imm={inst[15:0],16'h0}, dst=rt.
  - j (000010): target=inst[25:0], dst=0.
  - jr (R-type, funct 001000): rs only, dst=0.
  - slt (R-type, funct 101010): R-type field rules.
- Undefined: those encodings decode as und (op 7, fields 0) and increment und_count.

Test Plan:
- Reset then push addu $3,$1,$2 (0x00221821), pc=0x100, out_ready=1 -> next cycle out_valid=1, op=0, rs=1, rt=2, dst=3, wr_en=1, out_pc=0x100.
- Push lw $5,-4($4) (0x8C85FFFC) and ori $6,$0,0x8000 (0x34068000) -> lw: imm=0xFFFFFFFC, dst=5. ori: imm=0x00008000, dst=6.
- Hold out_ready=0 and push 5 instructions (DEPTH=4) -> in_ready=0 after 4 accepted while the slot holds the first. Release out_ready -> all 5 emerge in order, one per cycle.
- Queue 3 instructions, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0 and in_ready=1; none of the 4 instructions ever appears.
- Push 0xFC000000 three times, then lui $7,0x1234 (0x3C071234) -> und_count=3. With DECODE_EXT_OPS_EN: lui gives op=8, imm=0x12340000, dst=7. Without it: op=7 and und_count=4.
- Push jal 0x0000040 (0x0C000040) -> op=6, target=0x40, dst=31, wr_en=1.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO feeding a registered MIPS decode slot (valid/ready).
// Latency: an instruction accepted at edge N is on out_* after edge N+1; one per cycle when out_ready holds.
// Backpressure: in_ready = !full from registered occupancy; the slot holds its contents while out_ready is low.
// Build option: define DECODE_EXT_OPS_EN to also decode lui, j, jr and slt (otherwise they decode as und).
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dst,
  output logic [31:0]      out_imm,
  output logic [25:0]      out_target,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_wr_en,
  output logic [CNT_W-1:0] und_count
);

  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0]   occ_full = (aw+1)'(DEPTH);
  localparam logic [aw:0]   occ_one  = (aw+1)'(1);
  localparam logic [aw-1:0] ptr_one  = aw'(1);
  localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);

  localparam logic [3:0] op_addu = 4'd0;
  localparam logic [3:0] op_subu = 4'd1;
  localparam logic [3:0] op_ori  = 4'd2;
  localparam logic [3:0] op_lw   = 4'd3;
  localparam logic [3:0] op_sw   = 4'd4;
  localparam logic [3:0] op_beq  = 4'd5;
  localparam logic [3:0] op_jal  = 4'd6;
  localparam logic [3:0] op_und  = 4'd7;
  localparam logic [3:0] op_lui  = 4'd8;
  localparam logic [3:0] op_slt  = 4'd11;
`ifdef DECODE_EXT_OPS_EN
  localparam logic [3:0] op_j    = 4'd9;
  localparam logic [3:0] op_jr   = 4'd10;
`endif

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [aw-1:0]   wr_ptr, rd_ptr;
  logic [aw:0]     occ;
  logic            empty, push, load;
  logic [31:0]     head_inst;
  logic [PC_W-1:0] head_pc;

  logic [3:0]  d_op;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [31:0] d_imm;
  logic [25:0] d_target;
  logic        d_wr_en;

  assign empty     = (occ == '0);
  assign in_ready  = (occ != occ_full);
  assign push      = in_valid && in_ready && !flush;
  assign load      = (!out_valid || out_ready) && !empty && !flush;
  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Storage write: entries are only meaningful while counted by occ, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  // Pointers and occupancy; flush returns the queue to its empty state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (load) rd_ptr <= rd_ptr + ptr_one;
      case ({push, load})
        2'b10:   occ <= occ + occ_one;
        2'b01:   occ <= occ - occ_one;
        default: occ <= occ;
      endcase
    end
  end

  // Decode the FIFO head; unrecognised encodings fall through to und with all fields zero.
  always_comb begin
    d_op     = op_und;
    d_rs     = '0;
    d_rt     = '0;
    d_dst    = '0;
    d_imm    = '0;
    d_target = '0;
    case (head_inst[31:26])
      6'b000000: begin
        case (head_inst[5:0])
          6'b100001, 6'b100010: begin
            d_op  = (head_inst[5:0] == 6'b100001) ? op_addu : op_subu;
            d_rs  = head_inst[25:21];
            d_rt  = head_inst[20:16];
            d_dst = head_inst[15:11];
          end
`ifdef DECODE_EXT_OPS_EN
          6'b101010: begin
            d_op  = op_slt;
            d_rs  = head_inst[25:21];
            d_rt  = head_inst[20:16];
            d_dst = head_inst[15:11];
          end
          6'b001000: begin
            d_op = op_jr;
            d_rs = head_inst[25:21];
          end
`endif
          default: ;
        endcase
      end
      6'b001101: begin
        d_op  = op_ori;
        d_rs  = head_inst[25:21];
        d_rt  = head_inst[20:16];
        d_dst = head_inst[20:16];
        d_imm = {16'h0, head_inst[15:0]};
      end
      6'b100011: begin
        d_op  = op_lw;
        d_rs  = head_inst[25:21];
        d_rt  = head_inst[20:16];
        d_dst = head_inst[20:16];
        d_imm = {{16{head_inst[15]}}, head_inst[15:0]};
      end
      6'b101011, 6'b000100: begin
        d_op  = (head_inst[31:26] == 6'b101011) ? op_sw : op_beq;
        d_rs  = head_inst[25:21];
        d_rt  = head_inst[20:16];
        d_imm = {{16{head_inst[15]}}, head_inst[15:0]};
      end
      6'b000011: begin
        d_op     = op_jal;
        d_dst    = 5'd31;
        d_target = head_inst[25:0];
      end
`ifdef DECODE_EXT_OPS_EN
      6'b001111: begin
        d_op  = op_lui;
        d_rt  = head_inst[20:16];
        d_dst = head_inst[20:16];
        d_imm = {head_inst[15:0], 16'h0};
      end
      6'b000010: begin
        d_op     = op_j;
        d_target = head_inst[25:0];
      end
`endif
      default: ;
    endcase
    d_wr_en = (d_op inside {op_addu, op_subu, op_ori, op_lw, op_jal, op_lui, op_slt})
              && (d_dst != 5'd0);
  end

  // Output slot: load a decoded head when empty or being consumed, otherwise drain on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_op     <= op_und;
      out_rs     <= '0;
      out_rt     <= '0;
      out_dst    <= '0;
      out_imm    <= '0;
      out_target <= '0;
      out_pc     <= '0;
      out_wr_en  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_op     <= d_op;
      out_rs     <= d_rs;
      out_rt     <= d_rt;
      out_dst    <= d_dst;
      out_imm    <= d_imm;
      out_target <= d_target;
      out_pc     <= head_pc;
      out_wr_en  <= d_wr_en;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of undefined instructions entering the slot; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      und_count <= '0;
    end else if (load && (d_op == op_und) && (und_count != {CNT_W{1'b1}})) begin
      und_count <= und_count + cnt_one;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed stimulus with a scoreboard of hand-computed decode results.
// A forked monitor pops one expectation per consumed output-slot handshake.
// Expectations follow DECODE_EXT_OPS_EN so the bench suits either build.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_wr_en;
  logic [31:0] in_inst, in_pc, out_imm, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [25:0] out_target;
  logic [15:0] und_count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst), .out_imm(out_imm),
    .out_target(out_target), .out_pc(out_pc), .out_wr_en(out_wr_en),
    .und_count(und_count)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [25:0] target;
    logic [31:0] pc;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] dst, input logic [31:0] imm,
                              input logic [25:0] target, input logic [31:0] pc, input logic wr);
    exp_t e;
    e.op = op; e.rs = rs; e.rt = rt; e.dst = dst;
    e.imm = imm; e.target = target; e.pc = pc; e.wr = wr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Present one instruction and hold it until the queue accepts it (bounded wait).
  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for every expectation to be consumed, then one settle cycle.
  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, sb.size(), 32'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t ex_lui, ex_jr, ex_nop;
    int   und_after_lui, und_final;

`ifdef DECODE_EXT_OPS_EN
    und_after_lui = 3;
    und_final     = 4;
`else
    und_after_lui = 4;
    und_final     = 6;
`endif

    fork
      forever begin
        exp_t a, e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          a = mk(out_op, out_rs, out_rt, out_dst, out_imm, out_target, out_pc, out_wr_en);
          n_total++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_output: got op=%0d pc=0x%0h, expected no output", out_op, out_pc);
          end else begin
            e = sb.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL decode_pc_%0h: got op=%0d rs=%0d rt=%0d dst=%0d imm=0x%0h tgt=0x%0h pc=0x%0h wr=%0d, expected op=%0d rs=%0d rt=%0d dst=%0d imm=0x%0h tgt=0x%0h pc=0x%0h wr=%0d",
                          e.pc, a.op, a.rs, a.rt, a.dst, a.imm, a.target, a.pc, a.wr,
                          e.op, e.rs, e.rt, e.dst, e.imm, e.target, e.pc, e.wr);
          end
        end
      end
    join_none

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_und_count", {16'd0, und_count}, 32'd0);
    chk("reset_out_op",    {28'd0, out_op},    32'd7);
    chk("reset_out_dst",   {27'd0, out_dst},   32'd0);
    chk("reset_out_imm",   out_imm,            32'd0);
    chk("reset_out_pc",    out_pc,             32'd0);
    chk("reset_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // addu $3,$1,$2 and first-transaction latency
    sb.push_back(mk(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0, 32'h100, 1'b1));
    push(32'h00221821, 32'h100);
    chk("latency_edge_n", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_edge_n1", {31'd0, out_valid}, 32'd1);
    chk("latency_pc", out_pc, 32'h100);
    drain("drain_addu");

    // lw $5,-4($4) sign-extends; ori $6,$0,0x8000 zero-extends
    sb.push_back(mk(4'd3, 5'd4, 5'd5, 5'd5, 32'hFFFF_FFFC, 26'h0, 32'h104, 1'b1));
    sb.push_back(mk(4'd2, 5'd0, 5'd6, 5'd6, 32'h0000_8000, 26'h0, 32'h108, 1'b1));
    push(32'h8C85FFFC, 32'h104);
    push(32'h34068000, 32'h108);
    drain("drain_lw_ori");

    // Backpressure: slot holds the first, FIFO fills with four more
    out_ready = 1'b0;
    sb.push_back(mk(4'd4, 5'd4,  5'd5,  5'd0,  32'h0000_0008, 26'h0, 32'h200, 1'b0));
    sb.push_back(mk(4'd5, 5'd1,  5'd2,  5'd0,  32'hFFFF_FFFF, 26'h0, 32'h204, 1'b0));
    sb.push_back(mk(4'd1, 5'd7,  5'd8,  5'd9,  32'h0,         26'h0, 32'h208, 1'b1));
    sb.push_back(mk(4'd0, 5'd1,  5'd2,  5'd0,  32'h0,         26'h0, 32'h20C, 1'b0));
    sb.push_back(mk(4'd2, 5'd31, 5'd31, 5'd31, 32'h0000_FFFF, 26'h0, 32'h210, 1'b1));
    push(32'hAC850008, 32'h200);
    push(32'h1022FFFF, 32'h204);
    push(32'h00E84822, 32'h208);
    push(32'h00220021, 32'h20C);
    push(32'h37FFFFFF, 32'h210);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_slot_valid", {31'd0, out_valid}, 32'd1);
    chk("full_slot_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("throughput_valid", {31'd0, out_valid}, 32'd1);
    end
    drain("drain_backpressure");

    // Undefined opcodes, then lui
    sb.push_back(mk(4'd7, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 32'h300, 1'b0));
    sb.push_back(mk(4'd7, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 32'h304, 1'b0));
    sb.push_back(mk(4'd7, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 32'h308, 1'b0));
    push(32'hFC000000, 32'h300);
    push(32'hFC000000, 32'h304);
    push(32'hFC000000, 32'h308);
    drain("drain_und");
    chk("und_count_3", {16'd0, und_count}, 32'd3);
`ifdef DECODE_EXT_OPS_EN
    ex_lui = mk(4'd8, 5'd0, 5'd7, 5'd7, 32'h1234_0000, 26'h0, 32'h30C, 1'b1);
`else
    ex_lui = mk(4'd7, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 32'h30C, 1'b0);
`endif
    sb.push_back(ex_lui);
    push(32'h3C071234, 32'h30C);
    drain("drain_lui");
    chk("und_count_lui", {16'd0, und_count}, und_after_lui);

    // Flush with three queued and a fourth presented in the flush cycle
    out_ready = 1'b0;
    push(32'h00221821, 32'h400);
    push(32'h00221821, 32'h404);
    push(32'h00221821, 32'h408);
    in_valid = 1'b1; in_inst = 32'h00221821; in_pc = 32'h40C; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("flush_still_empty", {31'd0, out_valid}, 32'd0);
    chk("flush_keeps_und", {16'd0, und_count}, und_after_lui);

    // jal, nop (funct 0 is und), jr $31
    ex_nop = mk(4'd7, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 32'h504, 1'b0);
`ifdef DECODE_EXT_OPS_EN
    ex_jr = mk(4'd10, 5'd31, 5'd0, 5'd0, 32'h0, 26'h0, 32'h508, 1'b0);
`else
    ex_jr = mk(4'd7, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 32'h508, 1'b0);
`endif
    sb.push_back(mk(4'd6, 5'd0, 5'd0, 5'd31, 32'h0, 26'h40, 32'h500, 1'b1));
    sb.push_back(ex_nop);
    sb.push_back(ex_jr);
    push(32'h0C000040, 32'h500);
    push(32'h00000000, 32'h504);
    push(32'h03E00008, 32'h508);
    drain("drain_jal_nop_jr");
    chk("und_count_final", {16'd0, und_count}, und_final);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
